// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: bundle of the run-controller signals.
//   Control in : start, step, halt_req, mode, run_cycles
//   CPU side   : tmp_in (observed word), cpu_rst_n, cpu_en
//   Status     : cycle_cnt, busy, done, state_dbg (controller state for checkers)
//   Trace read : trace_rd_en, trace_data, trace_empty, trace_count, trace_ovf
// Trace read handshake: trace_data/trace_empty describe the FIFO head
// (first-word-fall-through); trace_rd_en acts as "ready" and the entry is
// consumed at the rising edge where trace_rd_en=1 and trace_empty=0.
// trace_rd_en with trace_empty=1 has no effect.
// master = host/bench side, slave = the controller.
interface cpu_run_ctrl_if #(
  parameter int DW  = 32,
  parameter int CW  = 16,
  parameter int TAW = 4
);
  logic          start;
  logic          step;
  logic          halt_req;
  logic [1:0]    mode;
  logic [CW-1:0] run_cycles;
  logic [DW-1:0] tmp_in;
  logic          trace_rd_en;
  logic          cpu_rst_n;
  logic          cpu_en;
  logic [CW-1:0] cycle_cnt;
  logic          busy;
  logic          done;
  logic [DW-1:0] trace_data;
  logic          trace_empty;
  logic [TAW:0]  trace_count;
  logic          trace_ovf;
  logic [2:0]    state_dbg;

  modport master (
    output start, step, halt_req, mode, run_cycles, tmp_in, trace_rd_en,
    input  cpu_rst_n, cpu_en, cycle_cnt, busy, done,
           trace_data, trace_empty, trace_count, trace_ovf, state_dbg
  );

  modport slave (
    input  start, step, halt_req, mode, run_cycles, tmp_in, trace_rd_en,
    output cpu_rst_n, cpu_en, cycle_cnt, busy, done,
           trace_data, trace_empty, trace_count, trace_ovf, state_dbg
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle CPU.
// Sequences CPU reset, gates the CPU clock enable in free-run, run-N or
// single-step mode, counts executed cycles and captures the CPU's observed
// output word into a trace FIFO on every executed cycle.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cpu_run_ctrl_if.slave (control, CPU side, status, trace read)
module cpu_run_ctrl #(
  parameter int DW          = 32,
  parameter int CW          = 16,
  parameter int RST_CYCLES  = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int TAW         = 4
) (
  input logic          clk,
  input logic          rst_n,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [1:0] M_RUN_N = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam int         HCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic [CW-1:0] run_cycles_q;
  logic [HCW-1:0] hold_cnt;
  logic [CW-1:0] cycle_cnt_q;
  logic          cpu_rst_n_q, cpu_en_q, busy_q, done_q;
  logic          start_acc;
  logic          last_run;

  // start is only honoured when no run is in progress
  assign start_acc = bus.start && (state == S_IDLE || state == S_DONE);

  // In RUN_N the cycle closing now is the last one when the count reaches
  // the target at this edge; compared one bit wider to avoid wrap.
  assign last_run = (mode_q == M_RUN_N) &&
                    (({1'b0, cycle_cnt_q} + 1'b1) == {1'b0, run_cycles_q});

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) state_nxt = S_RST_HOLD;
      end
      S_RST_HOLD: begin
        if (hold_cnt == '0) begin
          if (mode_q == M_STEP)                              state_nxt = S_STEP_WAIT;
          else if (mode_q == M_RUN_N && run_cycles_q == '0)  state_nxt = S_DONE;
          else                                               state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_run || bus.halt_req) state_nxt = S_DONE;
      end
      S_STEP_WAIT: begin
        if (bus.halt_req)  state_nxt = S_DONE;
        else if (bus.step) state_nxt = S_STEP_EXEC;
      end
      S_STEP_EXEC: state_nxt = S_STEP_WAIT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Control FSM; outputs are registered from the next state so they are a
  // pure function of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mode_q       <= 2'b00;
      run_cycles_q <= '0;
      hold_cnt     <= '0;
      cycle_cnt_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cpu_rst_n_q <= !(state_nxt == S_IDLE || state_nxt == S_RST_HOLD);
      cpu_en_q    <= (state_nxt == S_RUN || state_nxt == S_STEP_EXEC);
      busy_q      <= (state_nxt == S_RST_HOLD || state_nxt == S_RUN ||
                      state_nxt == S_STEP_WAIT || state_nxt == S_STEP_EXEC);
      done_q      <= (state_nxt == S_DONE);
      if (start_acc) begin
        mode_q       <= bus.mode;
        run_cycles_q <= bus.run_cycles;
        hold_cnt     <= HCW'(RST_CYCLES - 1);
        cycle_cnt_q  <= '0;
      end else begin
        if (state == S_RST_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        // cpu_en_q is high exactly during enabled cycles; saturate at all-ones
        if (cpu_en_q && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      end
    end
  end

  // Trace FIFO
  logic [DW-1:0]  mem [TRACE_DEPTH];
  logic [TAW-1:0] wr_ptr, rd_ptr;
  logic [TAW:0]   count_q;
  logic           ovf_q;
  logic           full, pop, push_ok;

  assign full    = (count_q == (TAW+1)'(TRACE_DEPTH));
  assign pop     = bus.trace_rd_en && (count_q != '0);
  // a pop in the same cycle frees the slot the push needs
  assign push_ok = cpu_en_q && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (start_acc) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (cpu_en_q && full && !pop) ovf_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !start_acc) mem[wr_ptr] <= bus.tmp_in;
  end

  assign bus.cpu_rst_n   = cpu_rst_n_q;
  assign bus.cpu_en      = cpu_en_q;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.trace_empty = (count_q == '0);
  assign bus.trace_count = count_q;
  assign bus.trace_data  = (count_q == '0) ? '0 : mem[rd_ptr];
  assign bus.trace_ovf   = ovf_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  localparam int DW          = 32;
  localparam int CW          = 16;
  localparam int RST_CYCLES  = 2;
  localparam int TRACE_DEPTH = 16;
  localparam int TAW         = 4;
  localparam int CNT_MAX     = (1 << CW) - 1;

  // model phases (bench-local numbering)
  localparam int P_IDLE = 10, P_HOLD = 11, P_RUN = 12, P_WAIT = 13, P_EXEC = 14, P_DONE = 15;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.DW(DW), .CW(CW), .TAW(TAW)) bus ();

  cpu_run_ctrl #(
    .DW(DW), .CW(CW), .RST_CYCLES(RST_CYCLES), .TRACE_DEPTH(TRACE_DEPTH), .TAW(TAW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int en_seen = 0;
  int rst_low_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int   m_phase   = P_IDLE;
  int   m_hold    = 0;
  int   m_enabled = 0;
  int   m_mode    = 0;
  int   m_rc      = 0;
  logic m_ovf     = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    m_phase = P_IDLE; m_hold = 0; m_enabled = 0; m_mode = 0; m_rc = 0; m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit en;
    en = (m_phase == P_RUN || m_phase == P_EXEC);
    if (bus.trace_rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
    if (en) begin
      if (exp_q.size() < TRACE_DEPTH) exp_q.push_back(bus.tmp_in);
      else m_ovf = 1'b1;
      m_enabled++;
    end
    case (m_phase)
      P_IDLE, P_DONE: if (bus.start) begin
        exp_q.delete();
        m_ovf = 1'b0; m_enabled = 0;
        m_mode = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
        m_rc = int'(bus.run_cycles);
        m_hold = RST_CYCLES;
        m_phase = P_HOLD;
      end
      P_HOLD: begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_mode == 2)                    m_phase = P_WAIT;
          else if (m_mode == 1 && m_rc == 0)  m_phase = P_DONE;
          else                                m_phase = P_RUN;
        end
      end
      P_RUN:  if ((m_mode == 1 && m_enabled == m_rc) || bus.halt_req) m_phase = P_DONE;
      P_WAIT: if (bus.halt_req) m_phase = P_DONE; else if (bus.step) m_phase = P_EXEC;
      P_EXEC: m_phase = P_WAIT;
      default: m_phase = P_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_edge();
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("cpu_rst_n", bus.cpu_rst_n, !(m_phase == P_IDLE || m_phase == P_HOLD));
    chk("cpu_en",    bus.cpu_en,    (m_phase == P_RUN || m_phase == P_EXEC));
    chk("busy",      bus.busy,      (m_phase == P_HOLD || m_phase == P_RUN ||
                                     m_phase == P_WAIT || m_phase == P_EXEC));
    chk("done",      bus.done,      (m_phase == P_DONE));
    chk("cycle_cnt", bus.cycle_cnt, (m_enabled > CNT_MAX) ? CNT_MAX : m_enabled);
    chk("trace_count", bus.trace_count, exp_q.size());
    chk("trace_empty", bus.trace_empty, (exp_q.size() == 0));
    chk("trace_data",  bus.trace_data,  (exp_q.size() == 0) ? '0 : exp_q[0]);
    chk("trace_ovf",   bus.trace_ovf,   m_ovf);
    if (bus.cpu_en)     en_seen++;
    if (!bus.cpu_rst_n) rst_low_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [1:0] md, input logic [CW-1:0] rc);
    bus.mode = md;
    bus.run_cycles = rc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    en_seen = 0;
    rst_low_seen = 0;
  endtask

  task automatic pop_check(input logic [DW-1:0] exp);
    chk("pop_data", bus.trace_data, exp);
    bus.trace_rd_en = 1'b1;
    tick();
    bus.trace_rd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 0; bus.step = 0; bus.halt_req = 0; bus.mode = 0;
    bus.run_cycles = 0; bus.tmp_in = 0; bus.trace_rd_en = 0;
    #2;
    chk("rst_cpu_rst_n", bus.cpu_rst_n, 0);
    chk("rst_cpu_en",    bus.cpu_en, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_done",      bus.done, 0);
    chk("rst_cycle_cnt", bus.cycle_cnt, 0);
    chk("rst_empty",     bus.trace_empty, 1);
    chk("rst_data",      bus.trace_data, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // RUN_N, 5 cycles, words 10..14
    start_run(2'b01, 16'd5);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      bus.tmp_in = 32'(10 + i);
      tick();
    end
    chk("t1_done", bus.done, 1);
    chk("t1_cnt", bus.cycle_cnt, 5);
    chk("t1_count", bus.trace_count, 5);
    chk("t1_en_cycles", en_seen, 5);
    chk("t1_rst_low_cycles", rst_low_seen, 2);
    for (int i = 0; i < 5; i++) pop_check(32'(10 + i));
    chk("t1_empty", bus.trace_empty, 1);

    // RUN_N with zero target
    start_run(2'b01, 16'd0);
    tick(2);
    chk("t2_done", bus.done, 1);
    tick(3);
    chk("t2_cnt", bus.cycle_cnt, 0);
    chk("t2_empty", bus.trace_empty, 1);
    chk("t2_en_cycles", en_seen, 0);

    // FREE, halt on 20th enabled cycle, no pops -> overflow
    start_run(2'b00, 16'd0);
    tick(2);
    for (int i = 0; i < 20; i++) begin
      bus.tmp_in = 32'(100 + i);
      bus.halt_req = (i == 19);
      tick();
    end
    bus.halt_req = 0;
    chk("t3_done", bus.done, 1);
    chk("t3_cnt", bus.cycle_cnt, 20);
    chk("t3_count", bus.trace_count, 16);
    chk("t3_ovf", bus.trace_ovf, 1);
    chk("t3_head", bus.trace_data, 100);

    // STEP mode
    start_run(2'b10, 16'd0);
    tick(4);
    chk("t4_wait_no_en", en_seen, 0);
    for (int p = 0; p < 2; p++) begin
      bus.tmp_in = 32'(300 + p);
      bus.step = 1; tick(); bus.step = 0; tick(3);
    end
    bus.tmp_in = 32'd302;
    bus.step = 1; tick(2); bus.step = 0; tick(2);
    chk("t4_en_cycles", en_seen, 3);
    chk("t4_cnt", bus.cycle_cnt, 3);
    chk("t4_busy", bus.busy, 1);
    bus.halt_req = 1; bus.step = 1; tick();
    bus.halt_req = 0; bus.step = 0; tick(2);
    chk("t4_done", bus.done, 1);
    chk("t4_en_after_halt", en_seen, 3);
    chk("t4_count", bus.trace_count, 3);

    // full FIFO with simultaneous push+pop, then drain and pop when empty
    start_run(2'b00, 16'd0);
    tick(2);
    for (int i = 0; i < 20; i++) begin
      bus.tmp_in = 32'(200 + i);
      bus.trace_rd_en = (i >= 16);
      bus.halt_req = (i == 19);
      tick();
    end
    bus.trace_rd_en = 0; bus.halt_req = 0;
    chk("t5_count", bus.trace_count, 16);
    chk("t5_ovf", bus.trace_ovf, 0);
    chk("t5_cnt", bus.cycle_cnt, 20);
    for (int i = 0; i < 16; i++) pop_check(32'(204 + i));
    bus.trace_rd_en = 1; tick(); bus.trace_rd_en = 0;
    chk("t5_empty_pop_data", bus.trace_data, 0);
    chk("t5_empty_pop_count", bus.trace_count, 0);
    chk("t5_empty_pop_empty", bus.trace_empty, 1);

    // asynchronous reset mid-run
    start_run(2'b01, 16'd10);
    tick(4);
    chk("t6_running", bus.cpu_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_cpu_rst_n", bus.cpu_rst_n, 0);
    chk("t6_rst_cpu_en", bus.cpu_en, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_cnt", bus.cycle_cnt, 0);
    chk("t6_rst_count", bus.trace_count, 0);
    chk("t6_rst_empty", bus.trace_empty, 1);
    tick(2);
    rst_n = 1'b1;
    tick();
    start_run(2'b01, 16'd3);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      bus.tmp_in = 32'(400 + i);
      tick();
    end
    chk("t6_done", bus.done, 1);
    chk("t6_cnt", bus.cycle_cnt, 3);
    chk("t6_en_cycles", en_seen, 3);
    chk("t6_head", bus.trace_data, 400);

    // randomized runs against the model
    for (int r = 0; r < 12; r++) begin
      start_run(2'($urandom_range(0, 3)), 16'($urandom_range(0, 6)));
      for (int c = 0; c < 40; c++) begin
        bus.step        = ($urandom_range(0, 2) == 0);
        bus.halt_req    = ($urandom_range(0, 11) == 0);
        bus.trace_rd_en = ($urandom_range(0, 2) == 0);
        bus.tmp_in      = $urandom;
        bus.start       = ($urandom_range(0, 19) == 0);
        bus.mode        = 2'($urandom_range(0, 3));
        bus.run_cycles  = 16'($urandom_range(0, 6));
        tick();
      end
      bus.step = 0; bus.halt_req = 0; bus.trace_rd_en = 0; bus.start = 0;
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
